// File: rtl/rx_hip2app_router.sv
// Routes HIP RX TLP beats to target / DMA-completion / misc app ports via an input reg and show-ahead skid FIFO.
// Latency: HIP beat at cycle N is presented on oRX_* at N+2 when the FIFO is empty.
// Backpressure: registered oRX_ST_READY drops when occupancy would exceed FIFO_DEPTH-(RDY_LAT+2).
module rx_hip2app_router #(
    parameter int RDY_LAT    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iRX_ST_VALID,
    input  logic                 iRX_ST_SOP,
    input  logic                 iRX_ST_EOP,
    input  logic [1:0]           iRX_ST_EMPTY,
    input  logic                 iRX_ST_ERR,
    input  logic [255:0]         iRX_ST_DATA,
    output logic                 oRX_ST_READY,
    output logic [2:0]           oRX_VALID,
    output logic                 oRX_SOP,
    output logic                 oRX_EOP,
    output logic [1:0]           oRX_EMPTY,
    output logic                 oRX_ERR,
    output logic [255:0]         oRX_DATA,
    input  logic [2:0]           iRX_READY,
    output logic [3*CNT_W-1:0]   oPKT_CNT,
    output logic                 oPROTO_ERR,
    output logic                 oOVERFLOW
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = 263;
    localparam int THR = FIFO_DEPTH - (RDY_LAT + 2);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_THR  = (AW+1)'(THR);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {W_IDLE = 1'b0, W_PKT = 1'b1} wstate_e;

    function automatic logic [1:0] decode_tag(input logic [4:0] fmt_type);
        case (fmt_type)
            5'b00000: decode_tag = 2'd0;
            5'b01010: decode_tag = 2'd1;
            default:  decode_tag = 2'd2;
        endcase
    endfunction

    wstate_e           state_q, state_d;
    logic              beat_acc;
    logic              proto_err_q, proto_err_d;
    logic [1:0]        tag_q, tag_d, sop_tag, beat_tag;
    logic              s1_vld_q, s1_vld_d;
    logic [EW-1:0]     s1_dat_q, s1_dat_d;
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  pkt_cnt_q [3];
    logic [CNT_W-1:0]  pkt_cnt_d [3];
    logic [EW-1:0]     head;
    logic [1:0]        head_port;
    logic              fifo_empty, fifo_full, do_pop, do_wr;

    // Write FSM: state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= W_IDLE;
        else         state_q <= state_d;
    end

    // Write FSM: next state
    always_comb begin
        state_d = state_q;
        if (iRX_ST_VALID) begin
            case (state_q)
                W_IDLE:  if (iRX_ST_SOP && !iRX_ST_EOP) state_d = W_PKT;
                W_PKT:   if (iRX_ST_EOP) state_d = W_IDLE;
                default: state_d = W_IDLE;
            endcase
        end
    end

    // Write FSM: outputs. A SOP inside a packet restarts framing rather than being dropped.
    always_comb begin
        beat_acc    = 1'b0;
        proto_err_d = 1'b0;
        if (iRX_ST_VALID) begin
            case (state_q)
                W_IDLE: begin
                    beat_acc    = iRX_ST_SOP;
                    proto_err_d = !iRX_ST_SOP;
                end
                W_PKT: begin
                    beat_acc    = 1'b1;
                    proto_err_d = iRX_ST_SOP;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sop_tag  = decode_tag(iRX_ST_DATA[28:24]);
        beat_tag = iRX_ST_SOP ? sop_tag : tag_q;
        tag_d    = (beat_acc && iRX_ST_SOP) ? sop_tag : tag_q;
        s1_vld_d = beat_acc;
        s1_dat_d = beat_acc ? {beat_tag, iRX_ST_SOP, iRX_ST_EOP, iRX_ST_EMPTY, iRX_ST_ERR, iRX_ST_DATA}
                            : s1_dat_q;
    end

    // FIFO entry: {tag[262:261], sop[260], eop[259], empty[258:257], err[256], data[255:0]}
    always_comb begin
        head       = fifo_mem[rd_ptr_q];
        head_port  = (head[262:261] == 2'd3) ? 2'd2 : head[262:261];
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_FULL);
        do_pop     = 1'b0;
        oRX_VALID  = 3'b000;
        if (!fifo_empty) begin
            case (head_port)
                2'd0:    begin do_pop = iRX_READY[0]; oRX_VALID = 3'b001; end
                2'd1:    begin do_pop = iRX_READY[1]; oRX_VALID = 3'b010; end
                default: begin do_pop = iRX_READY[2]; oRX_VALID = 3'b100; end
            endcase
        end
        // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
        do_wr    = s1_vld_q && (!fifo_full || do_pop);
        ovf_d    = ovf_q || (s1_vld_q && fifo_full && !do_pop);
        wr_ptr_d = do_wr  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr && !do_pop)      cnt_d = cnt_q + CNT_ONE;
        else if (!do_wr && do_pop) cnt_d = cnt_q - CNT_ONE;
        rdy_d    = (cnt_d <= CNT_THR);
    end

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            pkt_cnt_d[p] = pkt_cnt_q[p];
            if (do_pop && head[259] && head_port == 2'(p))
                pkt_cnt_d[p] = pkt_cnt_q[p] + CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            proto_err_q <= 1'b0;
            tag_q       <= 2'd0;
            s1_vld_q    <= 1'b0;
            s1_dat_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            ovf_q       <= 1'b0;
            for (int p = 0; p < 3; p++) pkt_cnt_q[p] <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            tag_q       <= tag_d;
            s1_vld_q    <= s1_vld_d;
            s1_dat_q    <= s1_dat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
            ovf_q       <= ovf_d;
            for (int p = 0; p < 3; p++) pkt_cnt_q[p] <= pkt_cnt_d[p];
        end
    end

    always_ff @(posedge iCLK) begin
        if (do_wr) fifo_mem[wr_ptr_q] <= s1_dat_q;
    end

    assign oRX_ST_READY = rdy_q;
    assign oRX_SOP      = head[260];
    assign oRX_EOP      = head[259];
    assign oRX_EMPTY    = head[258:257];
    assign oRX_ERR      = head[256];
    assign oRX_DATA     = head[255:0];
    assign oPKT_CNT     = {pkt_cnt_q[2], pkt_cnt_q[1], pkt_cnt_q[0]};
    assign oPROTO_ERR   = proto_err_q;
    assign oOVERFLOW    = ovf_q;

endmodule

// File: tb/tb_rx_hip2app_router.sv
// Directed bench for rx_hip2app_router; delivered beats are matched against a scoreboard queue.
module tb_rx_hip2app_router;
    logic         iCLK = 1'b0;
    logic         iRST_N = 1'b0;
    logic         iRX_ST_VALID = 1'b0;
    logic         iRX_ST_SOP = 1'b0;
    logic         iRX_ST_EOP = 1'b0;
    logic [1:0]   iRX_ST_EMPTY = 2'd0;
    logic         iRX_ST_ERR = 1'b0;
    logic [255:0] iRX_ST_DATA = '0;
    logic [2:0]   iRX_READY = 3'b000;
    logic         oRX_ST_READY;
    logic [2:0]   oRX_VALID;
    logic         oRX_SOP, oRX_EOP, oRX_ERR;
    logic [1:0]   oRX_EMPTY;
    logic [255:0] oRX_DATA;
    logic [47:0]  oPKT_CNT;
    logic         oPROTO_ERR, oOVERFLOW;

    typedef struct packed {
        logic [2:0]   vld;
        logic         sop;
        logic         eop;
        logic [1:0]   empty;
        logic         err;
        logic [255:0] data;
    } beat_t;

    beat_t      sbq[$];
    int         n_assert = 0;
    int         n_fail = 0;
    logic [1:0] mdl_tag = 2'd0;

    rx_hip2app_router #(.RDY_LAT(2), .FIFO_DEPTH(16), .CNT_W(16)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iRX_ST_VALID(iRX_ST_VALID), .iRX_ST_SOP(iRX_ST_SOP), .iRX_ST_EOP(iRX_ST_EOP),
        .iRX_ST_EMPTY(iRX_ST_EMPTY), .iRX_ST_ERR(iRX_ST_ERR), .iRX_ST_DATA(iRX_ST_DATA),
        .oRX_ST_READY(oRX_ST_READY), .oRX_VALID(oRX_VALID), .oRX_SOP(oRX_SOP),
        .oRX_EOP(oRX_EOP), .oRX_EMPTY(oRX_EMPTY), .oRX_ERR(oRX_ERR), .oRX_DATA(oRX_DATA),
        .iRX_READY(iRX_READY), .oPKT_CNT(oPKT_CNT), .oPROTO_ERR(oPROTO_ERR),
        .oOVERFLOW(oOVERFLOW)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [1:0] tag_of(input logic [4:0] ft);
        if (ft == 5'b00000)      tag_of = 2'd0;
        else if (ft == 5'b01010) tag_of = 2'd1;
        else                     tag_of = 2'd2;
    endfunction

    function automatic logic [255:0] rnd_beat(input logic [31:0] dw0, input logic use_dw0);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        if (use_dw0) d[31:0] = dw0;
        return d;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle();
        iRX_ST_VALID = 1'b0;
        iRX_ST_SOP   = 1'b0;
        iRX_ST_EOP   = 1'b0;
    endtask

    task automatic drive(input logic sop, input logic eop, input logic [255:0] d, input logic push);
        beat_t e;
        iRX_ST_VALID = 1'b1;
        iRX_ST_SOP   = sop;
        iRX_ST_EOP   = eop;
        iRX_ST_EMPTY = eop ? 2'd2 : 2'd0;
        iRX_ST_ERR   = d[40];
        iRX_ST_DATA  = d;
        if (push) begin
            if (sop) mdl_tag = tag_of(d[28:24]);
            e.vld   = 3'b001 << mdl_tag;
            e.sop   = sop;
            e.eop   = eop;
            e.empty = eop ? 2'd2 : 2'd0;
            e.err   = d[40];
            e.data  = d;
            sbq.push_back(e);
        end
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        idle();
        repeat (2) @(posedge iCLK);
        #1;
        sbq.delete();
        mdl_tag = 2'd0;
        check("rst_ready", 64'(oRX_ST_READY), 64'd0);
        check("rst_valid", 64'(oRX_VALID), 64'd0);
        check("rst_pktcnt", 64'(oPKT_CNT), 64'd0);
        check("rst_proto", 64'(oPROTO_ERR), 64'd0);
        check("rst_ovf", 64'(oOVERFLOW), 64'd0);
        iRST_N = 1'b1;
        @(negedge iCLK);
        check("rel_ready_lo", 64'(oRX_ST_READY), 64'd0);
        tick();
        @(negedge iCLK);
        check("rel_ready_hi", 64'(oRX_ST_READY), 64'd1);
        tick();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sbq.size() != 0 && k < 500) begin
            tick();
            k++;
        end
        check(tag, 64'(sbq.size()), 64'd0);
        tick();
        tick();
    endtask

    // Scoreboard: every pop on the selected port must match the oldest expected beat.
    always @(negedge iCLK) begin
        beat_t e, o;
        if (iRST_N === 1'b1 && oRX_VALID !== 3'b000) begin
            n_assert++;
            assert ($onehot(oRX_VALID)) else begin
                n_fail++;
                $error("FAIL onehot: observed %b expected one-hot", oRX_VALID);
            end
            if ((oRX_VALID & iRX_READY) != 3'b000) begin
                o = {oRX_VALID, oRX_SOP, oRX_EOP, oRX_EMPTY, oRX_ERR, oRX_DATA};
                n_assert++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $error("FAIL unexpected_beat: observed %0h expected none", o);
                end else begin
                    e = sbq.pop_front();
                    assert (o === e) else begin
                        n_fail++;
                        $error("FAIL beat: observed %0h expected %0h", o, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [255:0] b0;
        logic [1:0]   hist;
        logic         cur, dropped;
        int           sent, low_run;

        // MWr + one data beat: two-cycle latency, routed to target port
        do_reset();
        iRX_READY = 3'b111;
        drive(1'b1, 1'b0, rnd_beat(32'h4000_0001, 1'b1), 1'b1);
        tick();
        drive(1'b0, 1'b1, rnd_beat(32'h0, 1'b0), 1'b1);
        @(negedge iCLK);
        check("mwr_n1_vld", 64'(oRX_VALID), 64'd0);
        tick();
        idle();
        @(negedge iCLK);
        check("mwr_n2_vld", 64'(oRX_VALID), 64'(3'b001));
        check("mwr_n2_sop", 64'(oRX_SOP), 64'd1);
        tick();
        @(negedge iCLK);
        check("mwr_n3_vld", 64'(oRX_VALID), 64'(3'b001));
        check("mwr_n3_eop", 64'(oRX_EOP), 64'd1);
        drain("mwr_drain");
        check("mwr_cnt0", 64'(oPKT_CNT[15:0]), 64'd1);

        // CplD 4 beats with port1 stalled: head stays stable, nothing lost
        iRX_READY = 3'b101;
        b0 = rnd_beat(32'h4A00_0010, 1'b1);
        drive(1'b1, 1'b0, b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, rnd_beat(32'h0, 1'b0), 1'b1);
        tick();
        drive(1'b0, 1'b0, rnd_beat(32'h0, 1'b0), 1'b1);
        tick();
        drive(1'b0, 1'b1, rnd_beat(32'h0, 1'b0), 1'b1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("cpl_hold_vld", 64'(oRX_VALID), 64'(3'b010));
            check("cpl_hold_dat", oRX_DATA[63:0], b0[63:0]);
            tick();
        end
        iRX_READY = 3'b111;
        drain("cpl_drain");
        check("cpl_cnt1", 64'(oPKT_CNT[31:16]), 64'd1);

        // 20-beat stream honouring RDY_LAT with sinks stalled
        do_reset();
        iRX_READY = 3'b000;
        hist = 2'b11;
        dropped = 1'b0;
        sent = 0;
        low_run = 0;
        for (int c = 0; c < 300 && sent < 20; c++) begin
            cur = oRX_ST_READY;
            if (!cur) begin
                dropped = 1'b1;
                low_run++;
            end
            if (low_run >= 4) iRX_READY = 3'b111;
            if (hist[1]) begin
                drive(sent == 0, sent == 19, rnd_beat(32'h4000_0010, sent == 0), 1'b1);
                sent++;
            end else begin
                idle();
            end
            hist = {hist[0], cur};
            tick();
        end
        idle();
        check("flow_sent", 64'(sent), 64'd20);
        check("flow_rdy_dropped", 64'(dropped), 64'd1);
        iRX_READY = 3'b111;
        drain("flow_drain");
        check("flow_no_ovf", 64'(oOVERFLOW), 64'd0);
        check("flow_cnt0", 64'(oPKT_CNT[15:0]), 64'd1);

        // 20 beats ignoring READY: only the first 16 survive, overflow sticks
        do_reset();
        iRX_READY = 3'b000;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, rnd_beat(32'h3400_0000, 1'b1), i < 16);
            tick();
        end
        idle();
        repeat (3) tick();
        @(negedge iCLK);
        check("ovf_set", 64'(oOVERFLOW), 64'd1);
        check("ovf_ready_lo", 64'(oRX_ST_READY), 64'd0);
        iRX_READY = 3'b111;
        drain("ovf_drain");
        check("ovf_cnt2", 64'(oPKT_CNT[47:32]), 64'd16);
        check("ovf_sticky", 64'(oOVERFLOW), 64'd1);
        do_reset();

        // Framing errors: orphan beat dropped; SOP inside a packet restarts routing
        iRX_READY = 3'b111;
        drive(1'b0, 1'b1, rnd_beat(32'h0, 1'b0), 1'b0);
        tick();
        idle();
        @(negedge iCLK);
        check("orphan_pulse", 64'(oPROTO_ERR), 64'd1);
        check("orphan_vld", 64'(oRX_VALID), 64'd0);
        tick();
        @(negedge iCLK);
        check("orphan_pulse_end", 64'(oPROTO_ERR), 64'd0);
        check("orphan_vld2", 64'(oRX_VALID), 64'd0);
        tick();
        drive(1'b1, 1'b0, rnd_beat(32'h4000_0001, 1'b1), 1'b1);
        tick();
        drive(1'b1, 1'b0, rnd_beat(32'h4A00_0001, 1'b1), 1'b1);
        @(negedge iCLK);
        check("resop_no_pulse", 64'(oPROTO_ERR), 64'd0);
        tick();
        drive(1'b0, 1'b1, rnd_beat(32'h0, 1'b0), 1'b1);
        @(negedge iCLK);
        check("resop_pulse", 64'(oPROTO_ERR), 64'd1);
        tick();
        idle();
        @(negedge iCLK);
        check("resop_pulse_end", 64'(oPROTO_ERR), 64'd0);
        tick();
        drain("resop_drain");
        check("resop_cnt0", 64'(oPKT_CNT[15:0]), 64'd0);
        check("resop_cnt1", 64'(oPKT_CNT[31:16]), 64'd1);

        // Reset in the middle of a packet: continuation beat is an orphan
        drive(1'b1, 1'b0, rnd_beat(32'h4A00_0001, 1'b1), 1'b0);
        tick();
        idle();
        tick();
        do_reset();
        iRX_READY = 3'b111;
        drive(1'b0, 1'b1, rnd_beat(32'h0, 1'b0), 1'b0);
        tick();
        idle();
        @(negedge iCLK);
        check("midrst_pulse", 64'(oPROTO_ERR), 64'd1);
        repeat (3) tick();
        @(negedge iCLK);
        check("midrst_vld", 64'(oRX_VALID), 64'd0);
        check("midrst_cnt", 64'(oPKT_CNT), 64'd0);

        // Counter wrap on the misc port
        do_reset();
        iRX_READY = 3'b111;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b1, rnd_beat(32'h3400_0000, 1'b1), 1'b1);
            tick();
        end
        idle();
        drain("wrap_drain1");
        check("wrap_ffff", 64'(oPKT_CNT[47:32]), 64'hFFFF);
        drive(1'b1, 1'b1, rnd_beat(32'h3400_0000, 1'b1), 1'b1);
        tick();
        idle();
        drain("wrap_drain2");
        check("wrap_zero", 64'(oPKT_CNT[47:32]), 64'd0);
        check("wrap_no_ovf", 64'(oOVERFLOW), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
